// File: rtl/tape_ram_arbiter_pkg.sv
// Shared types for the tape/CPU RAM write-port arbiter.
// Contains no logic, so it adds no latency and applies no backpressure.
package tape_arb_pkg;

    // Widest tape address the FIFO entry can hold; the top's ADDR_W must not exceed it.
    localparam int TAPE_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        BANK_SET,
        DRAIN,
        FLUSH,
        BANK_RESTORE
    } arb_state_e;

    typedef struct packed {
        logic [TAPE_ADDR_W-1:0] addr;
        logic [7:0]             data;
    } tape_wr_t;

endpackage

// File: rtl/tape_ram_arbiter_if.sv
// Tape, CPU, bank and RAM signals of the arbiter. The arbiter uses the slave modport.
// The environment (tape parser, CPU decode, RAM/bank logic) uses the master modport.
interface tape_ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              dl_active;
    logic              tape_wr;
    logic [ADDR_W-1:0] tape_addr;
    logic [7:0]        tape_dout;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic [7:0]        bank_cur;
    logic              bank_we;
    logic [7:0]        bank_dout;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_src;
    logic              busy;
    logic              overflow;
    logic              load_done;

    modport master (
        output dl_active, tape_wr, tape_addr, tape_dout,
        output cpu_req, cpu_we, cpu_addr, cpu_dout, bank_cur,
        input  cpu_wait, bank_we, bank_dout, ram_we, ram_addr, ram_din,
        input  ram_src, busy, overflow, load_done
    );

    modport slave (
        input  dl_active, tape_wr, tape_addr, tape_dout,
        input  cpu_req, cpu_we, cpu_addr, cpu_dout, bank_cur,
        output cpu_wait, bank_we, bank_dout, ram_we, ram_addr, ram_din,
        output ram_src, busy, overflow, load_done
    );
endinterface

// File: rtl/tape_ram_arbiter_fifo.sv
// Synchronous FIFO of tape writes; head is the oldest entry, valid whenever !empty.
// Latency: a push is visible at head the next cycle. Push when full is ignored unless popping the same cycle.
// Backpressure: full/empty flags only; the caller decides what to drop.
module tape_wr_fifo
    import tape_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  tape_wr_t din,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output tape_wr_t head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tape_wr_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tape_ram_arbiter.sv
// Shares the RAM write port between the CPU and buffered tape bytes, bracketing each download with bank save/select/restore.
// Latency: a tape byte into an empty FIFO reaches RAM the next cycle if the CPU is not writing.
// Backpressure: tape bytes arriving with the FIFO full are dropped (sticky overflow); TAPE_CPU_HOLD_EN stalls the CPU via cpu_wait.
module tape_ram_arbiter
    import tape_arb_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] BANK_WR_VAL = 8'h00,
    parameter int         ADDR_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tape_ram_arbiter_if.slave    bus
);
    arb_state_e state, state_nxt;
    logic       dl_q;
    logic       dl_rise;
    logic [7:0] saved_bank;
    logic       overflow_q;
    logic       fifo_full, fifo_empty;
    logic       push, pop;
    logic       cpu_wr;
    logic       draining;
    logic       hold;
    tape_wr_t   head, wr_in;

    assign cpu_wr   = bus.cpu_req & bus.cpu_we;
    assign draining = (state == DRAIN) || (state == FLUSH);

`ifdef TAPE_CPU_HOLD_EN
    assign hold = (state != IDLE);
`else
    assign hold = 1'b0;
`endif
    assign bus.cpu_wait = hold;

    // While the CPU is held by WAIT its write request is frozen, so the tape takes the port.
    assign pop  = draining & ~fifo_empty & (hold | ~cpu_wr);
    assign push = bus.tape_wr & (~fifo_full | pop);

    // dl_q only follows dl_active in IDLE, so a level still high on return to IDLE counts as a new edge.
    assign dl_rise = (state == IDLE) & bus.dl_active & ~dl_q;

    always_comb begin
        wr_in = '0;
        wr_in.addr[ADDR_W-1:0] = bus.tape_addr;
        wr_in.data = bus.tape_dout;
    end

    tape_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (wr_in),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            saved_bank <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            dl_q  <= (state == IDLE) ? bus.dl_active : 1'b0;
            if (dl_rise) begin
                saved_bank <= bus.bank_cur;
                overflow_q <= 1'b0;
            end
            if (bus.tape_wr && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.bank_we   = 1'b0;
        bus.bank_dout = 8'h00;
        bus.load_done = 1'b0;
        case (state)
            IDLE: begin
                if (dl_rise) state_nxt = BANK_SET;
            end
            BANK_SET: begin
                bus.bank_we   = 1'b1;
                bus.bank_dout = BANK_WR_VAL;
                state_nxt     = DRAIN;
            end
            DRAIN: begin
                if (!bus.dl_active) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (fifo_empty) state_nxt = BANK_RESTORE;
            end
            BANK_RESTORE: begin
                bus.bank_we   = 1'b1;
                bus.bank_dout = saved_bank;
                bus.load_done = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_src  = 1'b0;
        bus.ram_addr = bus.cpu_addr;
        bus.ram_din  = bus.cpu_dout;
        if (pop) begin
            bus.ram_we   = 1'b1;
            bus.ram_src  = 1'b1;
            bus.ram_addr = head.addr[ADDR_W-1:0];
            bus.ram_din  = head.data;
        end else if (cpu_wr) begin
            bus.ram_we   = 1'b1;
        end
    end

    assign bus.busy     = (state != IDLE) | ~fifo_empty;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Directed download sequences plus randomized tape/CPU traffic against a queue-based model of RAM port ownership.
module tb_tape_ram_arbiter;
`ifdef TAPE_CPU_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tape_ram_arbiter_if #(.ADDR_W(16)) bus ();

    tape_ram_arbiter #(.FIFO_DEPTH(DEPTH), .BANK_WR_VAL(8'h00), .ADDR_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t mq[$];
    bit   movf;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle in DRAIN/FLUSH: predict who owns the RAM port from the queue, then update the queue.
    task automatic run_cycle(input bit tw, input logic [15:0] ta, input logic [7:0] td,
                             input bit cr, input bit cw, input logic [15:0] ca, input logic [7:0] cd);
        bit   cpuw, exp_pop;
        ent_t e;
        bus.tape_wr = tw; bus.tape_addr = ta; bus.tape_dout = td;
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_dout = cd;
        #1;
        cpuw    = cr && cw;
        exp_pop = (mq.size() > 0) && (HOLD || !cpuw);
        check("cpu_wait", bus.cpu_wait, HOLD);
        check("bank_we_drain", bus.bank_we, 0);
        if (exp_pop) begin
            e = mq.pop_front();
            check("tape_we", bus.ram_we, 1);
            check("tape_src", bus.ram_src, 1);
            check("tape_addr", bus.ram_addr, e.a);
            check("tape_data", bus.ram_din, e.d);
        end else if (cpuw) begin
            check("cpu_we", bus.ram_we, 1);
            check("cpu_src", bus.ram_src, 0);
            check("cpu_addr", bus.ram_addr, ca);
            check("cpu_data", bus.ram_din, cd);
        end else begin
            check("idle_we", bus.ram_we, 0);
            check("idle_src", bus.ram_src, 0);
            check("idle_addr", bus.ram_addr, ca);
        end
        if (tw) begin
            if (mq.size() < DEPTH) begin
                e.a = ta; e.d = td;
                mq.push_back(e);
            end else movf = 1'b1;
        end
        tick();
        bus.tape_wr = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        check("overflow", bus.overflow, movf);
    endtask

    task automatic start_download(input logic [7:0] b);
        bus.bank_cur = b;
        bus.dl_active = 1'b1;
        #1;
        check("idle_bank_we", bus.bank_we, 0);
        check("idle_wait", bus.cpu_wait, 0);
        tick();
        check("set_bank_we", bus.bank_we, 1);
        check("set_bank_dout", bus.bank_dout, 8'h00);
        check("set_busy", bus.busy, 1);
        check("set_wait", bus.cpu_wait, HOLD);
        check("set_ram_we", bus.ram_we, 0);
        movf = 1'b0;
        check("ovf_cleared", bus.overflow, 0);
        tick();
        check("drain_bank_we", bus.bank_we, 0);
    endtask

    task automatic drain_queue();
        int guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            run_cycle(0, 16'h0, 8'h0, 0, 0, 16'h1234, 8'h00);
            guard++;
        end
        check("drain_bound", mq.size(), 0);
        run_cycle(0, 16'h0, 8'h0, 0, 0, 16'h1234, 8'h00);
    endtask

    task automatic end_download(input logic [7:0] b);
        drain_queue();
        bus.dl_active = 1'b0;
        #1;
        check("drain_end_bank_we", bus.bank_we, 0);
        tick();
        check("flush_bank_we", bus.bank_we, 0);
        check("flush_busy", bus.busy, 1);
        check("flush_wait", bus.cpu_wait, HOLD);
        tick();
        check("rest_bank_we", bus.bank_we, 1);
        check("rest_bank_dout", bus.bank_dout, b);
        check("rest_load_done", bus.load_done, 1);
        check("rest_ram_we", bus.ram_we, 0);
        check("rest_wait", bus.cpu_wait, HOLD);
        tick();
        check("idle_bank_we2", bus.bank_we, 0);
        check("idle_load_done", bus.load_done, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_wait2", bus.cpu_wait, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_we"}, bus.ram_we, 0);
        check({tag, "_ram_src"}, bus.ram_src, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_bank_we"}, bus.bank_we, 0);
        check({tag, "_bank_dout"}, bus.bank_dout, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_overflow"}, bus.overflow, 0);
        check({tag, "_load_done"}, bus.load_done, 0);
        check({tag, "_cpu_wait"}, bus.cpu_wait, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dl_active = 0; bus.tape_wr = 0; bus.tape_addr = 0; bus.tape_dout = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_dout = 0; bus.bank_cur = 0;
        movf = 1'b0;
        #3;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Bank bracketing around a download carrying three tape bytes.
        start_download(8'h03);
        run_cycle(1, 16'h694D, 8'hAA, 0, 0, 16'h0000, 8'h00);
        run_cycle(1, 16'h694E, 8'hBB, 0, 0, 16'h0000, 8'h00);
        run_cycle(1, 16'h694F, 8'hCC, 0, 0, 16'h0000, 8'h00);
        run_cycle(0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        check("three_bytes_drained", mq.size(), 0);
        end_download(8'h03);

        // CPU writes held 10 cycles while four tape bytes arrive.
        start_download(8'h05);
        for (int i = 0; i < 10; i++)
            run_cycle(i < 4, 16'h7000 + 16'(i), 8'h10 + 8'(i), 1, 1, 16'h2000 + 16'(i), 8'h50 + 8'(i));
        check("queued_behind_cpu", mq.size(), HOLD ? 0 : 4);
        // Burst of nine tape bytes against continuous CPU writes.
        drain_queue();
        for (int i = 0; i < 9; i++)
            run_cycle(1, 16'h8000 + 16'(i), 8'(i * 3), 1, 1, 16'h3000, 8'hEE);
        check("ovf_set", bus.overflow, HOLD ? 0 : 1);
        end_download(8'h05);
        check("ovf_sticky_idle", bus.overflow, HOLD ? 0 : 1);

        // Randomized traffic; overflow cleared on the new dl_active rise.
        start_download(8'h07);
        for (int i = 0; i < 200; i++) begin
            bit cr = ($urandom_range(0, 2) == 0);
            run_cycle($urandom_range(0, 1) == 1, 16'($urandom), 8'($urandom),
                      cr, cr && ($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom));
        end
        end_download(8'h07);

        // Reset mid-DRAIN with bytes queued: no bank restore, everything back to reset values.
        start_download(8'h09);
        for (int i = 0; i < 3; i++)
            run_cycle(1, 16'h9000 + 16'(i), 8'hA0 + 8'(i), 1, 1, 16'h4000, 8'h44);
        bus.cpu_addr = 0; bus.cpu_dout = 0; bus.dl_active = 0;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        mq.delete();
        movf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("in_reset_bank_we", bus.bank_we, 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rel_bank_we", bus.bank_we, 0);
            check("rel_ram_we", bus.ram_we, 0);
            check("rel_busy", bus.busy, 0);
            check("rel_load_done", bus.load_done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
